// File: rtl/gc_conf_sequencer_pkg.sv
// Shared global-controller definitions: sequencer state encoding, select IDs, sizing helper.
package gc_conf_sequencer_pkg;

   localparam int unsigned GC_STATE_W  = 3;
   localparam int unsigned GC_SELECT_W = 3;

   localparam logic [GC_STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [GC_STATE_W-1:0] ST_CLR   = 3'd1;
   localparam logic [GC_STATE_W-1:0] ST_LOAD  = 3'd2;
   localparam logic [GC_STATE_W-1:0] ST_NEXT  = 3'd3;
   localparam logic [GC_STATE_W-1:0] ST_DONE  = 3'd4;
   localparam logic [GC_STATE_W-1:0] ST_ERROR = 3'd5;

   // Select value no target answers to; the bus is parked here between transfers.
   localparam logic [GC_SELECT_W-1:0] GC_IDLE_SEL = 3'b111;
   // Select ID of the initializer target.
   localparam logic [GC_SELECT_W-1:0] GC_INIT_SEL = 3'b010;
   // Default load order: entry k sits at bits [k*3 +: 3].
   localparam logic [4*GC_SELECT_W-1:0] GC_DEFAULT_SEL_LIST = {3'd3, 3'd2, 3'd1, 3'd0};

   // Index width that stays at least one bit for a single-entry range.
   function automatic int unsigned gc_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gc_conf_sequencer_watchdog_cnt.sv
// Consecutive-stall counter for the LOAD phase; expire flags the last allowed cycle.
module gc_watchdog_cnt
   import gc_conf_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned CNT_W = gc_idx_width(TIMEOUT_CYCLES)
) (
   input  logic conf_clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CNT_W-1:0] count;

   // Count stalled cycles; clear has priority and the count saturates at expiry.
   always_ff @(posedge conf_clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gc_conf_sequencer.sv
// Configuration sequencer: resets all targets, then streams host words to each target in list order.
module gc_conf_sequencer
   import gc_conf_sequencer_pkg::*;
#(
   parameter int unsigned NUM_TARGETS    = 4,
   parameter int unsigned SELECT_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter logic [NUM_TARGETS*SELECT_WIDTH-1:0] TARGET_SEL_LIST = GC_DEFAULT_SEL_LIST,
   parameter logic [SELECT_WIDTH-1:0]   IDLE_SEL       = GC_IDLE_SEL,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned CUR_W = gc_idx_width(NUM_TARGETS)
) (
   input  logic                    conf_clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_TARGETS-1:0]  conf_ack_vec,
   output logic [SELECT_WIDTH-1:0] sel,
   output logic [DATA_WIDTH-1:0]   conf_bus,
   output logic                    tgt_reset,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [CUR_W-1:0]        cur_target
);

   logic [GC_STATE_W-1:0]   state;
   logic [GC_STATE_W-1:0]   state_nxt;
   logic [CUR_W-1:0]        cur_nxt;
   logic [SELECT_WIDTH-1:0] sel_tab [NUM_TARGETS];
   logic                    cur_acked;
   logic                    last_target;
   logic                    xfer;
   logic                    wd_clear;
   logic                    wd_enable;
   logic                    wd_expire;

   // Unpack the select list into a per-target table.
   for (genvar k = 0; k < NUM_TARGETS; k++) begin : g_sel_tab
      assign sel_tab[k] = TARGET_SEL_LIST[k*SELECT_WIDTH +: SELECT_WIDTH];
   end

   assign cur_acked   = conf_ack_vec[cur_target];
   assign last_target = (cur_target == CUR_W'(NUM_TARGETS - 1));

   // Zero-latency transfer path: handshake, select and data follow the host directly.
   always_comb begin
      in_ready = (state == ST_LOAD) && !cur_acked && !abort;
      xfer     = in_ready && in_valid;
      sel      = IDLE_SEL;
      conf_bus = '0;
      if (xfer) begin
         sel      = sel_tab[cur_target];
         conf_bus = in_data;
      end
   end

   // Next-state, target index and watchdog control.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur_target;
      wd_clear  = 1'b0;
      wd_enable = 1'b0;
      if (abort) begin
         state_nxt = ST_IDLE;
         wd_clear  = 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state_nxt = ST_CLR;
                  cur_nxt   = '0;
                  wd_clear  = 1'b1;
               end
            end
            ST_CLR: begin
               state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               if (cur_acked) begin
                  state_nxt = ST_NEXT;
               end else if (xfer) begin
                  wd_clear = 1'b1;
               end else if (wd_expire) begin
                  state_nxt = ST_ERROR;
               end else begin
                  wd_enable = 1'b1;
               end
            end
            ST_NEXT: begin
               if (last_target) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_LOAD;
                  cur_nxt   = cur_target + CUR_W'(1);
                  wd_clear  = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State register with status flags registered from the upcoming state.
   always_ff @(posedge conf_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cur_target <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         tgt_reset  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur_target <= cur_nxt;
         busy       <= (state_nxt == ST_CLR) || (state_nxt == ST_LOAD) || (state_nxt == ST_NEXT);
         done       <= (state_nxt == ST_DONE);
         error      <= (state_nxt == ST_ERROR);
         tgt_reset  <= (state_nxt == ST_CLR);
      end
   end

   gc_watchdog_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .conf_clk (conf_clk),
      .reset_n  (reset_n),
      .clear    (wd_clear),
      .enable   (wd_enable),
      .expire   (wd_expire)
   );

endmodule

// File: tb/tb_gc_conf_sequencer.sv
// Randomized bench for gc_conf_sequencer against a word-count model of the targets.
module tb_gc_conf_sequencer;

   localparam int unsigned NT = 4;
   localparam int unsigned SW = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 8;
   localparam logic [NT*SW-1:0] SEL_LIST = {3'd1, 3'd4, 3'd6, 3'd2};
   localparam logic [SW-1:0]    IDLE     = 3'b111;

   logic          conf_clk = 1'b0;
   logic          reset_n  = 1'b0;
   logic          start    = 1'b0;
   logic          abort    = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NT-1:0] conf_ack_vec = '0;
   logic [SW-1:0] sel;
   logic [DW-1:0] conf_bus;
   logic          tgt_reset, busy, done, error;
   logic [1:0]    cur_target;

   int checks = 0;
   int passes = 0;

   // Target k answers to this select (entry k of SEL_LIST).
   logic [SW-1:0] exp_sel [NT] = '{3'd2, 3'd6, 3'd4, 3'd1};
   // Model: each target takes need[k] words and then acks.
   int need [NT];
   int got  [NT];

   always #5 conf_clk = ~conf_clk;

   gc_conf_sequencer #(
      .NUM_TARGETS     (NT),
      .SELECT_WIDTH    (SW),
      .DATA_WIDTH      (DW),
      .TARGET_SEL_LIST (SEL_LIST),
      .IDLE_SEL        (IDLE),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .conf_clk     (conf_clk),
      .reset_n      (reset_n),
      .start        (start),
      .abort        (abort),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .conf_ack_vec (conf_ack_vec),
      .sel          (sel),
      .conf_bus     (conf_bus),
      .tgt_reset    (tgt_reset),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .cur_target   (cur_target)
   );

   function automatic int model_target();
      for (int k = 0; k < NT; k++) if (got[k] < need[k]) return k;
      return NT;
   endfunction

   function automatic logic [NT-1:0] model_acks();
      logic [NT-1:0] v;
      for (int k = 0; k < NT; k++) v[k] = (got[k] >= need[k]);
      return v;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b1; in_data = 16'hABCD; conf_ack_vec = '0;
      repeat (2) @(negedge conf_clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
      checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passes++;
      checks++; if (tgt_reset !== 1'b0) $display("FAIL reset_tgt_reset: got %b want 0", tgt_reset); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (sel !== IDLE) $display("FAIL reset_sel: got %h want %h", sel, IDLE); else passes++;
      checks++; if (conf_bus !== '0) $display("FAIL reset_conf_bus: got %h want 0", conf_bus); else passes++;
      checks++; if (cur_target !== 2'd0) $display("FAIL reset_cur_target: got %0d want 0", cur_target); else passes++;
      reset_n = 1'b1;
      @(negedge conf_clk); #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
      in_valid = 1'b0;
   endtask

   // One full run. vmode: 0 valid high, 1 alternating, 2 random. stall: target starved of data (-1 none).
   task automatic run(input int n0, input int n1, input int n2, input int n3,
                      input int vmode, input int stall, input bit busy_start);
      int  k, xfers, pulses, since, cyc, tot;
      bit  fin, v, moved;
      need = '{n0, n1, n2, n3};
      got  = '{0, 0, 0, 0};
      tot  = n0 + n1 + n2 + n3;
      @(negedge conf_clk);
      start = 1'b1; abort = 1'b0; in_valid = 1'b0; conf_ack_vec = model_acks();
      @(negedge conf_clk);
      start = 1'b0;
      checks++; if (tgt_reset !== 1'b1) $display("FAIL run_tgt_reset_pulse: got %b want 1", tgt_reset); else passes++;
      checks++; if (busy !== 1'b1) $display("FAIL run_busy_start: got %b want 1", busy); else passes++;
      checks++; if (cur_target !== 2'd0) $display("FAIL run_cur_start: got %0d want 0", cur_target); else passes++;
      checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL run_flags_start: got done=%b error=%b want 0 0", done, error); else passes++;
      xfers = 0; pulses = 0; since = 0; fin = 1'b0; cyc = 0;
      while (cyc < 400 && !fin) begin
         if (tgt_reset === 1'b1) pulses++;
         if (done === 1'b1 || error === 1'b1) begin
            fin = 1'b1;
         end else begin
            k = model_target();
            case (vmode)
               0:       v = 1'b1;
               1:       v = (cyc % 2 == 0);
               default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (k == stall) v = 1'b0;
            in_valid     = v;
            in_data      = DW'($urandom);
            conf_ack_vec = model_acks();
            start        = busy_start && (busy === 1'b1) && ($urandom_range(0, 5) == 0);
            #1;
            moved = 1'b0;
            if (in_valid && in_ready === 1'b1) begin
               moved = 1'b1;
               checks++;
               if (k >= NT) $display("FAIL xfer_after_last: got sel=%h want no transfer", sel);
               else if (sel !== exp_sel[k]) $display("FAIL xfer_sel: got %h want %h (target %0d)", sel, exp_sel[k], k);
               else passes++;
               checks++; if (conf_bus !== in_data) $display("FAIL xfer_data: got %h want %h", conf_bus, in_data); else passes++;
               if (k < NT) got[k]++;
               xfers++;
            end else begin
               checks++; if (sel !== IDLE || conf_bus !== '0) $display("FAIL gap_idle: got sel=%h bus=%h want %h 0", sel, conf_bus, IDLE); else passes++;
            end
            if (k == NT && in_valid) begin
               checks++; if (in_ready !== 1'b0) $display("FAIL ready_after_acks: got %b want 0", in_ready); else passes++;
            end
            @(posedge conf_clk);
            since = moved ? 0 : since + 1;
            @(negedge conf_clk);
            cyc++;
         end
      end
      start = 1'b0; in_valid = 1'b1; #1;
      checks++; if (!fin) $display("FAIL run_budget: got no done/error in %0d cycles want completion", cyc); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL end_busy: got %b want 0", busy); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL end_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (pulses != 1) $display("FAIL tgt_reset_count: got %0d want 1", pulses); else passes++;
      if (stall < 0) begin
         checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL end_done: got done=%b error=%b want 1 0", done, error); else passes++;
         checks++; if (cur_target !== 2'(NT - 1)) $display("FAIL end_cur: got %0d want %0d", cur_target, NT - 1); else passes++;
         checks++; if (xfers != tot) $display("FAIL word_count: got %0d want %0d", xfers, tot); else passes++;
      end else begin
         checks++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL end_error: got error=%b done=%b want 1 0", error, done); else passes++;
         checks++; if (cur_target !== 2'(stall)) $display("FAIL error_cur: got %0d want %0d", cur_target, stall); else passes++;
         checks++; if (since != int'(TO) + 2) $display("FAIL timeout_latency: got %0d want %0d", since, TO + 2); else passes++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_single_stream();  run(9, 0, 0, 0, 0, -1, 1'b0); endtask
   task automatic test_stale_ack();      run(2, 0, 3, 1, 2, -1, 1'b1); endtask
   task automatic test_bubbles();        run(3, 2, 3, 2, 1, -1, 1'b0); endtask
   task automatic test_timeout();        run(2, 1, 100, 1, 0, 2, 1'b0); endtask

   task automatic test_random();
      repeat (5) run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5), 2, -1, 1'b1);
   endtask

   task automatic test_back_to_back();
      run(1, 1, 1, 1, 0, -1, 1'b0);
      run(2, 1, 0, 2, 2, -1, 1'b0);
   endtask

   task automatic test_abort_start();
      conf_ack_vec = '0;
      @(negedge conf_clk); start = 1'b1;
      @(negedge conf_clk); start = 1'b0; in_valid = 1'b1;
      repeat (3) @(negedge conf_clk);
      checks++; if (busy !== 1'b1) $display("FAIL abort_pre_busy: got %b want 1", busy); else passes++;
      abort = 1'b1; start = 1'b1; #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (sel !== IDLE || conf_bus !== '0) $display("FAIL abort_no_xfer: got sel=%h bus=%h want %h 0", sel, conf_bus, IDLE); else passes++;
      @(negedge conf_clk); abort = 1'b0; start = 1'b0; #1;
      checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passes++;
      checks++; if (tgt_reset !== 1'b0) $display("FAIL abort_tgt_reset: got %b want 0", tgt_reset); else passes++;
      checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL abort_flags: got done=%b error=%b want 0 0", done, error); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL abort_idle_ready: got %b want 0", in_ready); else passes++;
      in_valid = 1'b0;
      run(2, 3, 1, 2, 0, -1, 1'b0);
   endtask

   task automatic test_reset_mid();
      conf_ack_vec = '0;
      @(negedge conf_clk); start = 1'b1;
      @(negedge conf_clk); start = 1'b0; in_valid = 1'b1;
      repeat (3) @(negedge conf_clk);
      #2 reset_n = 1'b0; #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) $display("FAIL rst_mid_flags: got busy=%b done=%b error=%b want 0 0 0", busy, done, error); else passes++;
      checks++; if (tgt_reset !== 1'b0) $display("FAIL rst_mid_tgt_reset: got %b want 0", tgt_reset); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); else passes++;
      checks++; if (sel !== IDLE || conf_bus !== '0) $display("FAIL rst_mid_bus: got sel=%h bus=%h want %h 0", sel, conf_bus, IDLE); else passes++;
      checks++; if (cur_target !== 2'd0) $display("FAIL rst_mid_cur: got %0d want 0", cur_target); else passes++;
      @(negedge conf_clk); reset_n = 1'b1;
      repeat (3) begin
         #1;
         checks++; if (in_ready !== 1'b0 || sel !== IDLE || busy !== 1'b0) $display("FAIL rst_release_idle: got ready=%b sel=%h busy=%b want 0 %h 0", in_ready, sel, busy, IDLE); else passes++;
         @(negedge conf_clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_stream();
      test_stale_ack();
      test_bubbles();
      test_random();
      test_abort_start();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      run(2, 2, 2, 2, 2, -1, 1'b0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/gc_conf_sequencer.md
GC_CONF_SEQUENCER -- requirements
Module: gc_conf_sequencer

Interface
REQ-001 Parameter NUM_TARGETS, default 4: number of configurable target modules sequenced per run.
REQ-002 Parameter SELECT_WIDTH, default 3: width of the target select bus.
REQ-003 Parameter DATA_WIDTH, default 16: width of a configuration word.
REQ-004 Parameter TARGET_SEL_LIST, default {3'd3,3'd2,3'd1,3'd0}: packed select IDs in load order; entry k is bits [k*SELECT_WIDTH +: SELECT_WIDTH].
REQ-005 Parameter IDLE_SEL, default 3'b111: reserved select value owned by no target.
REQ-006 Parameter TIMEOUT_CYCLES, default 1024: maximum consecutive LOAD cycles without a consumed word.
REQ-007 conf_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins a configuration run.
REQ-010 abort  in  1  synchronous cancel of any run.
REQ-011 in_data  in  DATA_WIDTH  configuration word from the host stream.
REQ-012 in_valid  in  1  in_data is valid.
REQ-013 in_ready  out  1  word consumed on this edge when in_valid && in_ready.
REQ-014 conf_ack_vec  in  NUM_TARGETS  bit k is conf_ack of target k (list order).
REQ-015 sel  out  SELECT_WIDTH  target select; IDLE_SEL when no word is transferred.
REQ-016 conf_bus  out  DATA_WIDTH  configuration word to targets; zero when sel==IDLE_SEL.
REQ-017 tgt_reset  out  1  registered active-high reset pulse to all targets.
REQ-018 busy, done, error  out  1 each  run status flags.
REQ-019 cur_target  out  $clog2(NUM_TARGETS)  index of the target being loaded.

Function
REQ-020 States: IDLE, CLR, LOAD, NEXT, DONE, ERROR.
REQ-021 In IDLE, DONE, or ERROR, start with abort low: go to CLR, clear cur_target, clear the timeout counter, clear done and error.
REQ-022 CLR lasts exactly one cycle with tgt_reset=1, then LOAD; tgt_reset is 0 in all other states.
REQ-023 LOAD: in_ready = in_valid-independent (!conf_ack_vec[cur_target]); a transfer occurs when in_valid && in_ready.
REQ-024 During a transfer, sel = TARGET_SEL_LIST entry cur_target and conf_bus = in_data combinationally (zero latency); otherwise sel=IDLE_SEL and conf_bus=0.
REQ-025 LOAD with conf_ack_vec[cur_target]=1: no transfer; go to NEXT. This also applies on LOAD entry, so an already-acked target is skipped.
REQ-026 NEXT lasts one cycle. If cur_target==NUM_TARGETS-1, go to DONE; else increment cur_target, clear the timeout counter, and go to LOAD.
REQ-027 Timeout counter: cleared on each transfer; otherwise increments each LOAD cycle. When it reaches TIMEOUT_CYCLES-1 without a transfer or ack, go to ERROR.
REQ-028 DONE: done=1, busy=0, in_ready=0; hold until start, abort, or reset.
REQ-029 ERROR: error=1, busy=0, in_ready=0; cur_target holds the failing index.
REQ-030 busy=1 in CLR, LOAD, and NEXT.
REQ-031 abort in any state: next state IDLE; done and error cleared; no transfer in that cycle (in_ready forced to 0).
REQ-032 start and abort in the same cycle: abort wins.
REQ-033 start while busy: ignored.
REQ-034 Outputs other than in_ready, sel, and conf_bus are registered.

Reset
REQ-035 While reset_n=0: state=IDLE, cur_target=0, timeout counter=0, busy=0, done=0, error=0, tgt_reset=0, in_ready=0, sel=IDLE_SEL, conf_bus=0.
REQ-036 Reset mid-run discards progress; no partial state is retained after reset_n rises.

Structure
REQ-037 The state encoding, IDLE_SEL, and the default select IDs (initializer = 3'b010) belong in the shared global-controller package.
REQ-038 The timeout counter is the single sub-module gc_watchdog_cnt (clear, enable, expire outputs); everything else is flat.

Verification
REQ-039 Run initializer alone: NUM_TARGETS=1, list={3'b010}, DIMENSION=3; host streams 5+1+3 words with in_valid held high. Required: 9 transfers with sel=3'b010, then ack, then NEXT, then done=1; in_ready=0 from the ack cycle onward.
REQ-040 Bubbles: in_valid toggles 1,0,1,0. Required: sel=IDLE_SEL and conf_bus=0 in the gap cycles; word count and order unchanged.
REQ-041 Stale ack: conf_ack_vec=4'b0010 at start with no tgt_reset effect (stubbed target). Required: target 1 is skipped via LOAD->NEXT with no transfers to it.
REQ-042 Timeout: TIMEOUT_CYCLES=8, in_valid=0 in LOAD of target 2. Required: error=1 after 8 cycles, cur_target=2, tgt_reset never reasserted.
REQ-043 Abort and start in the same cycle mid-LOAD. Required: IDLE next cycle, no transfer, busy=0; a later start produces a one-cycle tgt_reset followed by a load from target 0.
REQ-044 reset_n low for 1 cycle mid-LOAD. Required: all REQ-035 values immediately (asynchronously); after release, IDLE with no spontaneous transfer.
